// File: rtl/hps_spi_master.sv
// SPI master for the HPS SPI slave link: 16-bit words, mode 0, MSB first, with multi-word frames.
// Optional build macro HPS_SPI_LOOPBACK_EN: receive path samples the internal mosi instead of spi_miso.
module hps_spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [15:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic        tx_last,
  input  logic [1:0]  tx_sel,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        busy,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs,
  output logic        fpga_enable,
  output logic        osd_enable,
  output logic        io_enable
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_LOW, ST_HIGH, ST_DONE, ST_WAIT, ST_HOLD, ST_DESEL
  } state_t;

  // Counter is 8 bits wide so CLK_DIV up to 255 never wraps.
  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  // DONE already supplies the first hold cycle, so HOLD runs CS_HOLD-1 cycles.
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 2);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] tx_sh_q, tx_sh_d;
  logic [15:0] rx_sh_q, rx_sh_d;
  logic [15:0] rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        last_q, last_d;
  logic [2:0]  en_q, en_d;
  logic        cs_q, cs_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;
  logic        accept;
  logic        sample_bit;

`ifdef HPS_SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = spi_miso;
  assign sample_bit  = mosi_q;
`else
  assign sample_bit  = spi_miso;
`endif

  // en bit 0 = fpga, 1 = osd, 2 = io; selector 3 aliases fpga.
  function automatic logic [2:0] sel_decode(input logic [1:0] sel);
    case (sel)
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

  assign accept = tx_valid & ready_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    last_d     = last_q;
    en_d       = en_q;
    cs_d       = cs_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cs_d    = 1'b0;
          en_d    = sel_decode(tx_sel);
          busy_d  = 1'b1;
          tx_sh_d = tx_data;
          mosi_d  = tx_data[15];
          last_d  = tx_last;
          cnt_d   = 8'd0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = 8'd0;
          bit_d   = 4'd0;
          state_d = ST_LOW;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_LOW: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = 8'd0;
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[14:0], sample_bit};
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_HIGH: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d  = 8'd0;
          sclk_d = 1'b0;
          if (bit_q == 4'd15) begin
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            bit_d   = bit_q + 4'd1;
            tx_sh_d = {tx_sh_q[14:0], 1'b0};
            mosi_d  = tx_sh_q[14];
            state_d = ST_LOW;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        cnt_d = 8'd0;
        if (!last_q) begin
          state_d = ST_WAIT;
        end else if (CS_HOLD == 1) begin
          cs_d    = 1'b1;
          en_d    = 3'b000;
          state_d = ST_DESEL;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_WAIT: begin
        // Continuation words skip SETUP and keep the frame's selector.
        if (accept) begin
          tx_sh_d = tx_data;
          mosi_d  = tx_data[15];
          last_d  = tx_last;
          bit_d   = 4'd0;
          cnt_d   = 8'd0;
          state_d = ST_LOW;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = 8'd0;
          cs_d    = 1'b1;
          en_d    = 3'b000;
          state_d = ST_DESEL;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DESEL: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = 8'd0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE) || (state_d == ST_WAIT);
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      bit_q      <= 4'd0;
      tx_sh_q    <= 16'd0;
      rx_sh_q    <= 16'd0;
      rx_data_q  <= 16'd0;
      rx_valid_q <= 1'b0;
      last_q     <= 1'b0;
      en_q       <= 3'b000;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      last_q     <= last_d;
      en_q       <= en_d;
      cs_q       <= cs_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  assign tx_ready    = ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = busy_q;
  assign spi_clk     = sclk_q;
  assign spi_mosi    = mosi_q;
  assign spi_cs      = cs_q;
  assign fpga_enable = en_q[0];
  assign osd_enable  = en_q[1];
  assign io_enable   = en_q[2];

endmodule

// File: tb/tb_hps_spi_master.sv
// Directed bench for hps_spi_master (CLK_DIV=4, CS_SETUP=2, CS_HOLD=2) with a mode-0 slave model on spi_miso.
module tb_hps_spi_master;
  logic        sys_clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] tx_data = 16'd0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        tx_last = 1'b0;
  logic [1:0]  tx_sel = 2'd0;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        busy;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_cs;
  logic        fpga_enable;
  logic        osd_enable;
  logic        io_enable;

  int checks = 0;
  int errors = 0;

`ifdef HPS_SPI_LOOPBACK_EN
  localparam bit LOOPBACK = 1'b1;
`else
  localparam bit LOOPBACK = 1'b0;
`endif

  always #5 sys_clk = ~sys_clk;

  hps_spi_master #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2)) dut (
    .sys_clk(sys_clk), .reset(reset),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last), .tx_sel(tx_sel),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs(spi_cs),
    .fpga_enable(fpga_enable), .osd_enable(osd_enable), .io_enable(io_enable)
  );

  // Slave model: presents bit 15 first, advances after each spi_clk fall, next word every 16 bits.
  logic [15:0] slave_words [0:3];
  logic [3:0]  idx = 4'd0;
  logic [1:0]  sw_n = 2'd0;
  assign spi_miso = slave_words[sw_n][~idx];

  logic        prev_clk = 1'b0;
  logic        prev_cs = 1'b1;
  int          rise_cnt = 0;
  int          rxv_cnt = 0;
  int          cs_low_cnt = 0;
  int          cs_rise_cnt = 0;
  logic [15:0] mosi_sh = 16'd0;

  always @(negedge sys_clk) begin
    prev_clk <= spi_clk;
    prev_cs  <= spi_cs;
    if (!spi_cs) cs_low_cnt <= cs_low_cnt + 1;
    if (spi_cs && !prev_cs) cs_rise_cnt <= cs_rise_cnt + 1;
    if (rx_valid) rxv_cnt <= rxv_cnt + 1;
    if (spi_clk && !prev_clk) begin
      rise_cnt <= rise_cnt + 1;
      mosi_sh  <= {mosi_sh[14:0], spi_mosi};
    end
    if (!spi_cs && prev_cs) begin
      idx  <= 4'd0;
      sw_n <= 2'd0;
    end else if (!spi_clk && prev_clk) begin
      idx <= idx + 4'd1;
      if (idx == 4'd15) sw_n <= sw_n + 2'd1;
    end
  end

  function automatic logic [15:0] exp_rx(input logic [15:0] tx, input logic [15:0] sl);
    return LOOPBACK ? tx : sl;
  endfunction

  // Called at a negedge; returns one negedge after the accepting clock edge.
  task automatic send_word(input logic [15:0] d, input logic last, input logic [1:0] sel, input bit hold);
    int n;
    tx_data = d; tx_last = last; tx_sel = sel; tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 2000) begin @(negedge sys_clk); n++; end
    checks++;
    if (!tx_ready) begin
      errors++;
      $display("FAIL accept_timeout: tx_ready=%b after %0d cycles, required 1", tx_ready, n);
      tx_valid = 1'b0;
      return;
    end
    @(negedge sys_clk);
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic wait_rx(output int n);
    n = 0;
    while (!rx_valid && n < 1000) begin @(negedge sys_clk); n++; end
    if (!rx_valid) n = -1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 1000) begin @(negedge sys_clk); n++; end
    if (busy) n = -1;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (spi_cs !== 1'b1) begin errors++; $display("FAIL rst_cs: got %b want 1", spi_cs); end
    checks++; if (spi_clk !== 1'b0) begin errors++; $display("FAIL rst_clk: got %b want 0", spi_clk); end
    checks++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi: got %b want 0", spi_mosi); end
    checks++; if ({io_enable, osd_enable, fpga_enable} !== 3'b000) begin errors++; $display("FAIL rst_en: got %b want 000", {io_enable, osd_enable, fpga_enable}); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", tx_ready); end
    checks++; if (rx_valid !== 1'b0 || rx_data !== 16'd0) begin errors++; $display("FAIL rst_rx: got %b/%h want 0/0000", rx_valid, rx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    @(negedge sys_clk); reset = 1'b1;
    @(negedge sys_clk); @(negedge sys_clk);
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_single_word;
    int n, r0, v0, l0;
    slave_words[0] = 16'h1234;
    r0 = rise_cnt; v0 = rxv_cnt; l0 = cs_low_cnt;
    send_word(16'hA55A, 1'b1, 2'd1, 1'b0);
    checks++; if ({io_enable, osd_enable, fpga_enable} !== 3'b010) begin errors++; $display("FAIL single_en: got %b want 010", {io_enable, osd_enable, fpga_enable}); end
    checks++; if (spi_cs !== 1'b0 || busy !== 1'b1 || tx_ready !== 1'b0) begin errors++; $display("FAIL single_start: cs/busy/ready got %b%b%b want 010", spi_cs, busy, tx_ready); end
    wait_rx(n);
    checks++; if (n < 0) begin errors++; $display("FAIL single_rx_timeout: got none want rx_valid"); end
    checks++; if (rx_data !== exp_rx(16'hA55A, 16'h1234)) begin errors++; $display("FAIL single_rx: got %h want %h", rx_data, exp_rx(16'hA55A, 16'h1234)); end
    n = 0;
    while (!spi_cs && n < 100) begin @(negedge sys_clk); n++; end
    n = 0;
    while (busy && spi_cs && n < 100) begin @(negedge sys_clk); n++; end
    checks++; if (n !== 4) begin errors++; $display("FAIL single_desel: busy after cs rise %0d cycles want 4", n); end
    @(negedge sys_clk); @(negedge sys_clk);
    checks++; if (rise_cnt - r0 !== 16) begin errors++; $display("FAIL single_rises: got %0d want 16", rise_cnt - r0); end
    checks++; if (mosi_sh !== 16'hA55A) begin errors++; $display("FAIL single_mosi: got %h want a55a", mosi_sh); end
    checks++; if (rxv_cnt - v0 !== 1) begin errors++; $display("FAIL single_rxv: got %0d want 1", rxv_cnt - v0); end
    checks++; if (cs_low_cnt - l0 !== 132) begin errors++; $display("FAIL single_cs_low: got %0d want 132", cs_low_cnt - l0); end
  endtask

  task automatic test_multi_word;
    int n, v0, l0, c0;
    slave_words[0] = 16'h8001; slave_words[1] = 16'h4002; slave_words[2] = 16'hC003;
    v0 = rxv_cnt; l0 = cs_low_cnt; c0 = cs_rise_cnt;
    send_word(16'h0001, 1'b0, 2'd2, 1'b0);
    checks++; if ({io_enable, osd_enable, fpga_enable} !== 3'b100) begin errors++; $display("FAIL multi_en: got %b want 100", {io_enable, osd_enable, fpga_enable}); end
    wait_rx(n);
    checks++; if (n < 0 || rx_data !== exp_rx(16'h0001, 16'h8001)) begin errors++; $display("FAIL multi_rx0: got %h (wait %0d) want %h", rx_data, n, exp_rx(16'h0001, 16'h8001)); end
    send_word(16'h0002, 1'b0, 2'd0, 1'b0);
    checks++; if ({io_enable, osd_enable, fpga_enable} !== 3'b100) begin errors++; $display("FAIL multi_en_cont: got %b want 100", {io_enable, osd_enable, fpga_enable}); end
    wait_rx(n);
    checks++; if (n < 0 || rx_data !== exp_rx(16'h0002, 16'h4002)) begin errors++; $display("FAIL multi_rx1: got %h (wait %0d) want %h", rx_data, n, exp_rx(16'h0002, 16'h4002)); end
    send_word(16'h0003, 1'b1, 2'd3, 1'b0);
    checks++; if (cs_rise_cnt - c0 !== 0) begin errors++; $display("FAIL multi_cs_mid: got %0d rises want 0", cs_rise_cnt - c0); end
    wait_rx(n);
    checks++; if (n < 0 || rx_data !== exp_rx(16'h0003, 16'hC003)) begin errors++; $display("FAIL multi_rx2: got %h (wait %0d) want %h", rx_data, n, exp_rx(16'h0003, 16'hC003)); end
    wait_idle(n);
    @(negedge sys_clk);
    checks++; if (cs_low_cnt - l0 !== 392) begin errors++; $display("FAIL multi_cs_low: got %0d want 392", cs_low_cnt - l0); end
    checks++; if (rxv_cnt - v0 !== 3) begin errors++; $display("FAIL multi_rxv: got %0d want 3", rxv_cnt - v0); end
    checks++; if (cs_rise_cnt - c0 !== 1) begin errors++; $display("FAIL multi_cs_end: got %0d rises want 1", cs_rise_cnt - c0); end
  endtask

  task automatic test_stall;
    int n, bad;
    slave_words[0] = 16'h5A5A; slave_words[1] = 16'h0FF0;
    send_word(16'h3C3C, 1'b0, 2'd0, 1'b0);
    wait_rx(n);
    checks++; if (n < 0 || rx_data !== exp_rx(16'h3C3C, 16'h5A5A)) begin errors++; $display("FAIL stall_rx0: got %h want %h", rx_data, exp_rx(16'h3C3C, 16'h5A5A)); end
    @(negedge sys_clk);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (spi_cs !== 1'b0 || spi_clk !== 1'b0 || tx_ready !== 1'b1) bad++;
      @(negedge sys_clk);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stall_hold: %0d bad cycles want 0", bad); end
    checks++; if ({io_enable, osd_enable, fpga_enable} !== 3'b001) begin errors++; $display("FAIL stall_en: got %b want 001", {io_enable, osd_enable, fpga_enable}); end
    send_word(16'hC3C3, 1'b1, 2'd1, 1'b0);
    wait_rx(n);
    checks++; if (n < 0 || rx_data !== exp_rx(16'hC3C3, 16'h0FF0)) begin errors++; $display("FAIL stall_rx1: got %h want %h", rx_data, exp_rx(16'hC3C3, 16'h0FF0)); end
    wait_idle(n);
    checks++; if (n < 0 || spi_cs !== 1'b1 || {io_enable, osd_enable, fpga_enable} !== 3'b000) begin errors++; $display("FAIL stall_end: cs=%b en=%b want 1/000", spi_cs, {io_enable, osd_enable, fpga_enable}); end
  endtask

  task automatic test_back_to_back;
    int n, hi;
    slave_words[0] = 16'h7E81;
    send_word(16'h1111, 1'b1, 2'd1, 1'b1);
    tx_data = 16'h2222; tx_sel = 2'd0; tx_last = 1'b1;
    wait_rx(n);
    checks++; if (n < 0 || rx_data !== exp_rx(16'h1111, 16'h7E81)) begin errors++; $display("FAIL b2b_rx0: got %h want %h", rx_data, exp_rx(16'h1111, 16'h7E81)); end
    n = 0;
    while (!spi_cs && n < 100) begin @(negedge sys_clk); n++; end
    hi = 0;
    while (spi_cs && hi < 100) begin @(negedge sys_clk); hi++; end
    tx_valid = 1'b0;
    checks++; if (hi !== 5) begin errors++; $display("FAIL b2b_cs_high: got %0d cycles want 5", hi); end
    checks++; if ({io_enable, osd_enable, fpga_enable} !== 3'b001) begin errors++; $display("FAIL b2b_en: got %b want 001", {io_enable, osd_enable, fpga_enable}); end
    wait_rx(n);
    checks++; if (n < 0 || rx_data !== exp_rx(16'h2222, 16'h7E81)) begin errors++; $display("FAIL b2b_rx1: got %h want %h", rx_data, exp_rx(16'h2222, 16'h7E81)); end
    wait_idle(n);
    checks++; if (n < 0) begin errors++; $display("FAIL b2b_idle: busy stuck, want 0"); end
  endtask

  task automatic test_reset_mid_frame;
    int n, r0, v0;
    slave_words[0] = 16'hFFFF;
    v0 = rxv_cnt;
    r0 = rise_cnt;
    send_word(16'h9696, 1'b1, 2'd2, 1'b0);
    n = 0;
    while (rise_cnt - r0 < 9 && n < 500) begin @(negedge sys_clk); n++; end
    checks++; if (rise_cnt - r0 < 9) begin errors++; $display("FAIL mid_reach_bit7: got %0d rises want 9", rise_cnt - r0); end
    #2 reset = 1'b0;
    #1;
    checks++; if (spi_cs !== 1'b1 || spi_clk !== 1'b0) begin errors++; $display("FAIL mid_async_pins: cs/clk got %b%b want 10", spi_cs, spi_clk); end
    checks++; if ({io_enable, osd_enable, fpga_enable} !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL mid_async_en: en=%b busy=%b want 000/0", {io_enable, osd_enable, fpga_enable}, busy); end
    @(negedge sys_clk); reset = 1'b1;
    @(negedge sys_clk); @(negedge sys_clk);
    checks++; if (tx_ready !== 1'b1 || busy !== 1'b0 || spi_cs !== 1'b1) begin errors++; $display("FAIL mid_idle: ready/busy/cs got %b%b%b want 101", tx_ready, busy, spi_cs); end
    repeat (40) @(negedge sys_clk);
    checks++; if (rxv_cnt - v0 !== 0) begin errors++; $display("FAIL mid_no_rxv: got %0d pulses want 0", rxv_cnt - v0); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) slave_words[i] = 16'h0000;
    test_reset();
    test_single_word();
    test_multi_word();
    test_stall();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
